// File: rtl/countdown_timer_pkg.sv
// timer_pkg: shared types, digit limits and BCD helpers for the mm:ss countdown timer.
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX = 4'd9;
  function automatic logic [15:0] bcd_sanitise(input logic [15:0] v);
    bcd_t m1, m0, s1, s0;
    m1 = (v[15:12] > DIGIT_MAX) ? DIGIT_MAX : v[15:12];
    m0 = (v[11:8] > DIGIT_MAX) ? DIGIT_MAX : v[11:8];
    s1 = (v[7:4] > SEC_TENS_MAX) ? SEC_TENS_MAX : v[7:4];
    s0 = (v[3:0] > DIGIT_MAX) ? DIGIT_MAX : v[3:0];
    return {m1, m0, s1, s0};
  endfunction
  // Borrows ripple S0 -> S1 -> M0 -> M1; callers never pass 0000.
  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    bcd_t m1, m0, s1, s0;
    {m1, m0, s1, s0} = c;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else if (s1 != 4'd0) begin
      s0 = DIGIT_MAX;
      s1 = s1 - 4'd1;
    end else begin
      s0 = DIGIT_MAX;
      s1 = SEC_TENS_MAX;
      if (m0 != 4'd0) m0 = m0 - 4'd1;
      else begin
        m0 = DIGIT_MAX;
        m1 = m1 - 4'd1;
      end
    end
    return {m1, m0, s1, s0};
  endfunction
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs and display/status outputs of the countdown timer.
interface countdown_timer_if;
  logic load;
  logic [15:0] load_value;
  logic start;
  logic pause;
  logic [15:0] digits;
  logic running;
  logic done;
  logic expired_pulse;
  modport master(output load, load_value, start, pause, input digits, running, done, expired_pulse);
  modport slave(input load, load_value, start, pause, output digits, running, done, expired_pulse);
endinterface

// File: rtl/countdown_timer_slow_tick_sync.sv
// slow_tick_sync: synchronises slow_clock into CLOCK_50 and emits a one-cycle tick per rising edge.
module slow_tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic slow_clock,
  output logic tick
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], slow_clock};
      hist <= sync[SYNC_STAGES-1];
    end
  end
  assign tick = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: start/pause/load controlled mm:ss BCD countdown driven by synchronised slow_clock ticks.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic CLOCK_50,
  input logic reset_n,
  input logic slow_clock,
  countdown_timer_if.slave bus
);
  timer_state_t state;
  logic [15:0] count;
  logic pulse;
  logic tick;
  slow_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLOCK_50(CLOCK_50),
    .reset_n(reset_n),
    .slow_clock(slow_clock),
    .tick(tick)
  );
  // Load beats everything; pause beats start; ticks only matter in RUN.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (bus.load) begin
        count <= bcd_sanitise(bus.load_value);
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (!bus.pause && bus.start && count != '0) state <= RUN;
          RUN:
            if (bus.pause) state <= PAUSE;
            else if (tick) begin
              count <= bcd_dec(count);
              if (count == 16'h0001) begin
                state <= DONE;
                pulse <= 1'b1;
              end
            end
          PAUSE: if (!bus.pause && bus.start) state <= RUN;
          default: ;
        endcase
      end
    end
  end
  assign bus.digits = count;
  assign bus.running = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.expired_pulse = pulse;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus with a seconds-based reference model checked every cycle.
module tb_countdown_timer;
  localparam int S = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic slow_clock = 1'b0;
  int vectors = 0, miscompares = 0, n_pulse = 0;
  countdown_timer_if ifc();
  countdown_timer #(.SYNC_STAGES(S)) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .slow_clock(slow_clock),
    .bus(ifc.slave)
  );
  always #5 clk = ~clk;
  // Reference model: count held as total seconds, state as a plain mode number.
  int m_secs = 0, m_mode = M_IDLE;
  bit m_pulse = 1'b0, armed = 1'b0;
  logic [S:0] samp = '0;
  wire m_tick = samp[S-1] & ~samp[S];
  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction
  function automatic int secs_of(input logic [15:0] v);
    return (clampi(int'(v[15:12]), 9) * 10 + clampi(int'(v[11:8]), 9)) * 60
         + clampi(int'(v[7:4]), 5) * 10 + clampi(int'(v[3:0]), 9);
  endfunction
  function automatic logic [15:0] to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction
  always @(posedge clk) begin
    armed <= 1'b1;
    if (!reset_n) begin
      m_secs <= 0;
      m_mode <= M_IDLE;
      m_pulse <= 1'b0;
      samp <= '0;
    end else begin
      samp <= {samp[S-1:0], slow_clock};
      m_pulse <= 1'b0;
      if (ifc.load) begin
        m_secs <= secs_of(ifc.load_value);
        m_mode <= M_IDLE;
      end else if (m_mode == M_IDLE && !ifc.pause && ifc.start && m_secs > 0) m_mode <= M_RUN;
      else if (m_mode == M_RUN && ifc.pause) m_mode <= M_PAUSE;
      else if (m_mode == M_RUN && m_tick) begin
        m_secs <= m_secs - 1;
        if (m_secs == 1) begin
          m_mode <= M_DONE;
          m_pulse <= 1'b1;
        end
      end else if (m_mode == M_PAUSE && !ifc.pause && ifc.start) m_mode <= M_RUN;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      if ({ifc.digits, ifc.running, ifc.done, ifc.expired_pulse} !== {to_bcd(m_secs), m_mode == M_RUN, m_mode == M_DONE, m_pulse}) begin
        miscompares++;
        $display("FAIL model t=%0t got digits=%h run=%b done=%b pulse=%b exp digits=%h run=%b done=%b pulse=%b",
                 $time, ifc.digits, ifc.running, ifc.done, ifc.expired_pulse,
                 to_bcd(m_secs), m_mode == M_RUN, m_mode == M_DONE, m_pulse);
      end
      if (ifc.expired_pulse === 1'b1) n_pulse++;
    end
  end
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_load(input logic [15:0] v);
    ifc.load = 1'b1;
    ifc.load_value = v;
    cyc(1);
    ifc.load = 1'b0;
  endtask
  task automatic do_start();
    ifc.start = 1'b1;
    cyc(1);
    ifc.start = 1'b0;
  endtask
  task automatic rise();
    slow_clock = 1'b1;
    cyc(8);
    slow_clock = 1'b0;
    cyc(8);
  endtask
  logic [15:0] steps [4] = '{16'h0101, 16'h0100, 16'h0059, 16'h0058};
  int p0;
  initial begin
    ifc.load = 1'b0;
    ifc.load_value = '0;
    ifc.start = 1'b0;
    ifc.pause = 1'b0;
    for (int i = 0; i < 120; i++) begin
      slow_clock = ((i / 8) % 2) == 1;
      reset_n = (i >= 3);
      cyc(1);
    end
    check("reset_digits", ifc.digits, 16'h0000);
    check("reset_flags", {14'd0, ifc.running, ifc.done}, 16'h0000);
    check("reset_no_pulse", 16'(n_pulse), 16'd0);
    do_load(16'h0102);
    do_start();
    check("start_running", {15'd0, ifc.running}, 16'h0001);
    slow_clock = 1'b1;
    cyc(2);
    check("latency_before", ifc.digits, 16'h0102);
    cyc(1);
    check("latency_after", ifc.digits, 16'h0101);
    cyc(5);
    slow_clock = 1'b0;
    cyc(8);
    for (int i = 1; i < 4; i++) begin
      rise();
      check("step", ifc.digits, steps[i]);
    end
    do_load(16'h0002);
    do_start();
    p0 = n_pulse;
    rise();
    rise();
    check("expire_digits", ifc.digits, 16'h0000);
    check("expire_done", {15'd0, ifc.done}, 16'h0001);
    check("expire_one_pulse", 16'(n_pulse - p0), 16'd1);
    do_start();
    rise();
    rise();
    check("done_sticky", {ifc.digits[13:0], ifc.running, ifc.done}, 16'h0001);
    check("done_no_repulse", 16'(n_pulse - p0), 16'd1);
    do_load(16'h0031);
    do_start();
    rise();
    check("pre_pause", ifc.digits, 16'h0030);
    slow_clock = 1'b1;
    cyc(2);
    ifc.pause = 1'b1;
    cyc(1);
    ifc.pause = 1'b0;
    cyc(5);
    slow_clock = 1'b0;
    cyc(8);
    check("pause_drop_tick", ifc.digits, 16'h0030);
    repeat (5) rise();
    check("paused_digits", ifc.digits, 16'h0030);
    check("paused_running", {15'd0, ifc.running}, 16'h0000);
    do_start();
    rise();
    check("resume", ifc.digits, 16'h0029);
    do_load(16'h9F7C);
    check("sanitise", ifc.digits, 16'h9959);
    p0 = n_pulse;
    ifc.start = 1'b1;
    do_load(16'h0000);
    ifc.start = 1'b0;
    do_start();
    cyc(2);
    check("zero_start", {ifc.digits[13:0], ifc.running, ifc.done}, 16'h0000);
    check("zero_no_pulse", 16'(n_pulse - p0), 16'd0);
    do_load(16'h0516);
    do_start();
    rise();
    check("mid_run", ifc.digits, 16'h0515);
    slow_clock = 1'b1;
    cyc(1);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    check("midreset_digits", ifc.digits, 16'h0000);
    check("midreset_flags", {13'd0, ifc.running, ifc.done, ifc.expired_pulse}, 16'h0000);
    cyc(7);
    slow_clock = 1'b0;
    cyc(8);
    do_load(16'h0003);
    do_start();
    p0 = n_pulse;
    repeat (3) rise();
    check("final_done", {ifc.digits[13:0], ifc.running, ifc.done}, 16'h0001);
    check("final_pulse", 16'(n_pulse - p0), 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
